// File: rtl/tcm_loader.sv
// tcm_loader: streams a byte image into tcm_mem through the mem_d_* write port,
// packing bytes little-endian into strobed 32-bit writes with in-order tags,
// and holds the core in reset until every write has been acknowledged.
`timescale 1ns/1ps
module tcm_loader #(
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned LEN_W           = 20
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [LEN_W-1:0] length_i,
   input  logic             byte_valid_i,
   input  logic [7:0]       byte_data_i,
   output logic             byte_ready_o,
   output logic [31:0]      mem_d_addr_o,
   output logic [31:0]      mem_d_data_wr_o,
   output logic             mem_d_rd_o,
   output logic [3:0]       mem_d_wr_o,
   output logic             mem_d_cacheable_o,
   output logic [10:0]      mem_d_req_tag_o,
   output logic             mem_d_invalidate_o,
   output logic             mem_d_writeback_o,
   output logic             mem_d_flush_o,
   input  logic             mem_d_accept_i,
   input  logic             mem_d_ack_i,
   input  logic             mem_d_error_i,
   input  logic [10:0]      mem_d_resp_tag_i,
   input  logic [31:0]      mem_d_data_rd_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             error_o,
   output logic             core_rst_o
);

   localparam int unsigned TAG_W = 11;
   localparam int unsigned OUT_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_next;

   logic [LEN_W-1:0]   r_bytes_left, w_bytes_left_next;
   logic [1:0]         r_lane,       w_lane_next;
   logic [31:0]        r_word,       w_word_next;
   logic [31:0]        r_addr,       w_addr_next;
   logic [31:0]        r_req_addr,   w_req_addr_next;
   logic [31:0]        r_req_data,   w_req_data_next;
   logic [3:0]         r_req_wr,     w_req_wr_next;
   logic [TAG_W-1:0]   r_tag,        w_tag_next;
   logic [TAG_W-1:0]   r_exp_tag,    w_exp_tag_next;
   logic [OUT_W-1:0]   r_outstanding, w_out_next;
   logic               r_error,      w_error_next;
   logic               r_byte_ready, w_ready_next;
   logic               r_busy;
   logic               r_done;
   logic               r_core_rst;

   logic               w_acc;
   logic               w_ack;
   logic               w_byte_fire;
   logic [31:0]        w_filled;
   logic [3:0]         w_strobe;
   logic               w_unused_rd;

   // Read data is never consumed by a write-only initiator.
   assign w_unused_rd = ^mem_d_data_rd_i;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state, packing, request hold, tag and outstanding bookkeeping.
   always_comb begin
      w_state_next      = r_state;
      w_bytes_left_next = r_bytes_left;
      w_lane_next       = r_lane;
      w_word_next       = r_word;
      w_addr_next       = r_addr;
      w_req_addr_next   = r_req_addr;
      w_req_data_next   = r_req_data;
      w_req_wr_next     = r_req_wr;
      w_tag_next        = r_tag;
      w_exp_tag_next    = r_exp_tag;
      w_out_next        = r_outstanding;
      w_error_next      = r_error;

      w_acc       = (r_req_wr != 4'b0000) && mem_d_accept_i;
      w_ack       = mem_d_ack_i && (r_state != ST_IDLE);
      w_byte_fire = r_byte_ready && byte_valid_i;
      w_filled    = r_word | (32'(byte_data_i) << {r_lane, 3'b000});
      w_strobe    = 4'((5'd2 << r_lane) - 5'd1);

      // Accepted request: retire it and advance the request tag.
      if (w_acc) begin
         w_req_wr_next = 4'b0000;
         w_tag_next    = r_tag + TAG_W'(1);
      end

      // Responses must arrive in issue order and without error.
      if (w_ack) begin
         w_exp_tag_next = r_exp_tag + TAG_W'(1);
         if ((mem_d_resp_tag_i != r_exp_tag) || mem_d_error_i) begin
            w_error_next = 1'b1;
         end
      end

      // Outstanding count; a simultaneous accept and ack cancel out.
      case ({w_acc, w_ack})
         2'b10: w_out_next = r_outstanding + OUT_W'(1);
         2'b01: begin
            if (r_outstanding == OUT_W'(0)) begin
               w_error_next = 1'b1;
            end else begin
               w_out_next = r_outstanding - OUT_W'(1);
            end
         end
         default: ;
      endcase

      // Byte intake: a full word or the final byte becomes a held request.
      if (w_byte_fire) begin
         w_bytes_left_next = r_bytes_left - LEN_W'(1);
         if ((r_lane == 2'd3) || (r_bytes_left == LEN_W'(1))) begin
            w_req_addr_next = r_addr;
            w_req_data_next = w_filled;
            w_req_wr_next   = w_strobe;
            w_addr_next     = r_addr + 32'd4;
            w_word_next     = 32'h0;
            w_lane_next     = 2'd0;
         end else begin
            w_word_next = w_filled;
            w_lane_next = r_lane + 2'd1;
         end
      end

      case (r_state)
         ST_IDLE: begin
            if (start_i) begin
               if (length_i == '0) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_state_next      = ST_LOAD;
                  w_bytes_left_next = length_i;
                  w_lane_next       = 2'd0;
                  w_word_next       = 32'h0;
                  w_addr_next       = BASE_ADDR;
               end
            end
         end
         ST_LOAD: begin
            // A same-cycle ack of the last write lets DONE follow immediately.
            if (w_acc && (r_bytes_left == '0)) begin
               w_state_next = (w_out_next == OUT_W'(0)) ? ST_DONE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_out_next == OUT_W'(0)) begin
               w_state_next = ST_DONE;
            end
         end
         default: ;
      endcase

      w_ready_next = (w_state_next == ST_LOAD) && (w_bytes_left_next != '0) &&
                     (w_req_wr_next == 4'b0000) &&
                     (w_out_next < OUT_W'(MAX_OUTSTANDING));
   end

   // Datapath and registered status outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_bytes_left  <= '0;
         r_lane        <= 2'd0;
         r_word        <= 32'h0;
         r_addr        <= BASE_ADDR;
         r_req_addr    <= 32'h0;
         r_req_data    <= 32'h0;
         r_req_wr      <= 4'b0000;
         r_tag         <= '0;
         r_exp_tag     <= '0;
         r_outstanding <= '0;
         r_error       <= 1'b0;
         r_byte_ready  <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_core_rst    <= 1'b1;
      end else begin
         r_bytes_left  <= w_bytes_left_next;
         r_lane        <= w_lane_next;
         r_word        <= w_word_next;
         r_addr        <= w_addr_next;
         r_req_addr    <= w_req_addr_next;
         r_req_data    <= w_req_data_next;
         r_req_wr      <= w_req_wr_next;
         r_tag         <= w_tag_next;
         r_exp_tag     <= w_exp_tag_next;
         r_outstanding <= w_out_next;
         r_error       <= w_error_next;
         r_byte_ready  <= w_ready_next;
         r_busy        <= (w_state_next == ST_LOAD) || (w_state_next == ST_DRAIN);
         r_done        <= (w_state_next == ST_DONE);
         r_core_rst    <= (w_state_next != ST_DONE);
      end
   end

   assign byte_ready_o       = r_byte_ready;
   assign mem_d_addr_o       = r_req_addr;
   assign mem_d_data_wr_o    = r_req_data;
   assign mem_d_wr_o         = r_req_wr;
   assign mem_d_req_tag_o    = r_tag;
   assign mem_d_rd_o         = 1'b0;
   assign mem_d_cacheable_o  = 1'b0;
   assign mem_d_invalidate_o = 1'b0;
   assign mem_d_writeback_o  = 1'b0;
   assign mem_d_flush_o      = 1'b0;
   assign busy_o             = r_busy;
   assign done_o             = r_done;
   assign error_o            = r_error;
   assign core_rst_o         = r_core_rst;

endmodule

// File: tb/tb_tcm_loader.sv
// Bench for tcm_loader: byte stream driver, responding memory model and a
// scoreboard of expected write requests built as the bytes are streamed.
`timescale 1ns/1ps
module tb_tcm_loader;

   localparam int unsigned MAXO = 2;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [19:0] length_i;
   logic        byte_valid_i;
   logic [7:0]  byte_data_i;
   logic        byte_ready_o;
   logic [31:0] mem_d_addr_o;
   logic [31:0] mem_d_data_wr_o;
   logic        mem_d_rd_o;
   logic [3:0]  mem_d_wr_o;
   logic        mem_d_cacheable_o;
   logic [10:0] mem_d_req_tag_o;
   logic        mem_d_invalidate_o;
   logic        mem_d_writeback_o;
   logic        mem_d_flush_o;
   logic        mem_d_accept_i;
   logic        mem_d_ack_i;
   logic        mem_d_error_i;
   logic [10:0] mem_d_resp_tag_i;
   logic [31:0] mem_d_data_rd_i;
   logic        busy_o;
   logic        done_o;
   logic        error_o;
   logic        core_rst_o;

   always #5 clk = ~clk;

   tcm_loader #(
      .BASE_ADDR       (32'h0000_0000),
      .MAX_OUTSTANDING (MAXO),
      .LEN_W           (20)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .start_i            (start_i),
      .length_i           (length_i),
      .byte_valid_i       (byte_valid_i),
      .byte_data_i        (byte_data_i),
      .byte_ready_o       (byte_ready_o),
      .mem_d_addr_o       (mem_d_addr_o),
      .mem_d_data_wr_o    (mem_d_data_wr_o),
      .mem_d_rd_o         (mem_d_rd_o),
      .mem_d_wr_o         (mem_d_wr_o),
      .mem_d_cacheable_o  (mem_d_cacheable_o),
      .mem_d_req_tag_o    (mem_d_req_tag_o),
      .mem_d_invalidate_o (mem_d_invalidate_o),
      .mem_d_writeback_o  (mem_d_writeback_o),
      .mem_d_flush_o      (mem_d_flush_o),
      .mem_d_accept_i     (mem_d_accept_i),
      .mem_d_ack_i        (mem_d_ack_i),
      .mem_d_error_i      (mem_d_error_i),
      .mem_d_resp_tag_i   (mem_d_resp_tag_i),
      .mem_d_data_rd_i    (mem_d_data_rd_i),
      .busy_o             (busy_o),
      .done_o             (done_o),
      .error_o            (error_o),
      .core_rst_o         (core_rst_o)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  wr;
      logic [10:0] tag;
   } req_t;

   req_t        exp_q[$];
   logic [10:0] ack_tag_q[$];
   int          ack_due_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit mm_en = 1'b0;
   int acc_cnt, ack_cnt, last_ack_cyc, done_cyc, first_ack_cyc, third_acc_cyc;
   int hold_first, hold_cnt, ack_delay, bad_tag_idx, err_idx, wr_seen;
   bit held;
   req_t held_req, mm_cur, mm_exp;
   logic [10:0] exp_tag;

   // Memory model: decides accept/ack at negedge so the next posedge samples them.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (done_o && done_cyc < 0) done_cyc = cyc;
         if (mem_d_wr_o != 4'b0000) wr_seen++;
         if (mm_en) begin
            mem_d_accept_i = 1'b0;
            if (mem_d_wr_o != 4'b0000) begin
               mm_cur = {mem_d_addr_o, mem_d_data_wr_o, mem_d_wr_o, mem_d_req_tag_o};
               if (held) begin
                  checks++;
                  if (mm_cur !== held_req) begin
                     errors++;
                     $display("FAIL hold_stable got %h expected %h", mm_cur, held_req);
                  end
               end
               if (hold_cnt < hold_first) begin
                  checks++;
                  if (byte_ready_o !== 1'b0) begin
                     errors++;
                     $display("FAIL hold_ready got %b expected 0", byte_ready_o);
                  end
                  held     = 1'b1;
                  held_req = mm_cur;
                  hold_cnt++;
               end else begin
                  mem_d_accept_i = 1'b1;
                  held       = 1'b0;
                  hold_cnt   = 0;
                  hold_first = 0;
                  checks++;
                  if (acc_cnt - ack_cnt >= int'(MAXO)) begin
                     errors++;
                     $display("FAIL outstanding_limit got %0d in flight before accept, limit %0d",
                              acc_cnt - ack_cnt, MAXO);
                  end
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_write got addr=%h data=%h wr=%h tag=%h expected none",
                              mem_d_addr_o, mem_d_data_wr_o, mem_d_wr_o, mem_d_req_tag_o);
                  end else begin
                     mm_exp = exp_q.pop_front();
                     if (mm_cur !== mm_exp) begin
                        errors++;
                        $display("FAIL write_fields got addr=%h data=%h wr=%h tag=%h expected addr=%h data=%h wr=%h tag=%h",
                                 mm_cur.addr, mm_cur.data, mm_cur.wr, mm_cur.tag,
                                 mm_exp.addr, mm_exp.data, mm_exp.wr, mm_exp.tag);
                     end
                  end
                  if (acc_cnt == 2) third_acc_cyc = cyc;
                  acc_cnt++;
                  ack_tag_q.push_back(mem_d_req_tag_o);
                  ack_due_q.push_back(cyc + ack_delay);
               end
            end
            mem_d_ack_i      = 1'b0;
            mem_d_error_i    = 1'b0;
            mem_d_resp_tag_i = 11'd0;
            if (ack_due_q.size() > 0 && ack_due_q[0] <= cyc) begin
               mem_d_ack_i      = 1'b1;
               mem_d_resp_tag_i = ack_tag_q[0] ^ ((ack_cnt == bad_tag_idx) ? 11'd1 : 11'd0);
               mem_d_error_i    = (ack_cnt == err_idx);
               void'(ack_tag_q.pop_front());
               void'(ack_due_q.pop_front());
               if (ack_cnt == 0) first_ack_cyc = cyc;
               ack_cnt++;
               last_ack_cyc = cyc;
            end
         end
      end
   end

   task automatic do_reset();
      mm_en = 1'b0;
      rst_i = 1'b1; start_i = 1'b0; length_i = '0;
      byte_valid_i = 1'b0; byte_data_i = 8'h00;
      mem_d_accept_i = 1'b0; mem_d_ack_i = 1'b0; mem_d_error_i = 1'b0;
      mem_d_resp_tag_i = 11'd0; mem_d_data_rd_i = 32'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      exp_q.delete(); ack_tag_q.delete(); ack_due_q.delete();
      exp_tag = 11'd0; acc_cnt = 0; ack_cnt = 0;
      last_ack_cyc = -1; done_cyc = -1; first_ack_cyc = -1; third_acc_cyc = -1;
      held = 1'b0; hold_cnt = 0; hold_first = 0; ack_delay = 0;
      bad_tag_idx = -1; err_idx = -1; wr_seen = 0;
   endtask

   task automatic start_load(input int n);
      start_i = 1'b1; length_i = 20'(n);
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   // Streams n bytes first, first+1, ...; each completed word is pushed to the scoreboard.
   task automatic stream(input int n, input logic [7:0] first);
      logic [31:0] w;
      logic [3:0]  m;
      int t;
      w = 32'h0;
      for (int i = 0; i < n; i++) begin
         byte_valid_i = 1'b1;
         byte_data_i  = 8'(first + 8'(i));
         t = 0;
         forever begin
            @(negedge clk);
            if (byte_ready_o) break;
            t++;
            if (t > 2000) break;
         end
         if (t > 2000) begin
            checks++; errors++;
            $display("FAIL stream_timeout got no byte_ready for byte %0d expected ready", i);
            byte_valid_i = 1'b0;
            return;
         end
         @(posedge clk); #1;
         w = w | (32'(byte_data_i) << (8 * (i % 4)));
         if ((i % 4) == 3 || i == n - 1) begin
            case (i % 4)
               0: m = 4'b0001;
               1: m = 4'b0011;
               2: m = 4'b0111;
               default: m = 4'b1111;
            endcase
            exp_q.push_back({32'(4 * (i / 4)), w, m, exp_tag});
            exp_tag = exp_tag + 11'd1;
            w = 32'h0;
         end
      end
      byte_valid_i = 1'b0;
   endtask

   task automatic wait_done(input int nw);
      int t;
      t = 0;
      while (done_cyc < 0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk); #1;
      checks++;
      if (done_cyc < 0) begin
         errors++;
         $display("FAIL done_timeout got done_o=%b expected 1", done_o);
      end else begin
         checks++;
         if (done_cyc != last_ack_cyc + 1) begin
            errors++;
            $display("FAIL done_timing got done cycle %0d expected %0d", done_cyc, last_ack_cyc + 1);
         end
      end
      checks++;
      if (done_o !== 1'b1 || core_rst_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL done_outputs got done=%b core_rst=%b busy=%b expected 1 0 0",
                  done_o, core_rst_o, busy_o);
      end
      checks++;
      if (ack_cnt != nw || exp_q.size() != 0) begin
         errors++;
         $display("FAIL write_count got acks=%0d pending=%0d expected acks=%0d pending=0",
                  ack_cnt, exp_q.size(), nw);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (mem_d_wr_o !== 4'b0 || byte_ready_o !== 1'b0 || busy_o !== 1'b0 ||
          done_o !== 1'b0 || error_o !== 1'b0 || core_rst_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_values got wr=%h rdy=%b busy=%b done=%b err=%b core_rst=%b expected 0 0 0 0 0 1",
                  mem_d_wr_o, byte_ready_o, busy_o, done_o, error_o, core_rst_o);
      end
      checks++;
      if ({mem_d_rd_o, mem_d_cacheable_o, mem_d_invalidate_o, mem_d_writeback_o, mem_d_flush_o} !== 5'b0) begin
         errors++;
         $display("FAIL tie_offs got %b expected 00000",
                  {mem_d_rd_o, mem_d_cacheable_o, mem_d_invalidate_o, mem_d_writeback_o, mem_d_flush_o});
      end
   endtask

   task automatic test_basic();
      do_reset();
      mm_en = 1'b1;
      start_load(8);
      checks++;
      if (busy_o !== 1'b1 || core_rst_o !== 1'b1 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL load_status got busy=%b core_rst=%b done=%b expected 1 1 0", busy_o, core_rst_o, done_o);
      end
      stream(8, 8'h01);
      wait_done(2);
      checks++;
      if (error_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_error got %b expected 0", error_o);
      end
   endtask

   task automatic test_partial();
      do_reset();
      mm_en = 1'b1;
      start_load(6);
      stream(6, 8'hAA);
      wait_done(2);
   endtask

   task automatic test_backpressure();
      do_reset();
      mm_en = 1'b1;
      hold_first = 5;
      start_load(8);
      stream(8, 8'h10);
      wait_done(2);
   endtask

   task automatic test_outstanding();
      do_reset();
      mm_en = 1'b1;
      ack_delay = 10;
      start_load(16);
      stream(16, 8'h40);
      wait_done(4);
      checks++;
      if (third_acc_cyc <= first_ack_cyc) begin
         errors++;
         $display("FAIL third_after_ack got third accept %0d first ack %0d expected later",
                  third_acc_cyc, first_ack_cyc);
      end
      checks++;
      if (error_o !== 1'b0) begin
         errors++;
         $display("FAIL order_error got %b expected 0", error_o);
      end
   endtask

   task automatic test_errors();
      do_reset();
      mm_en = 1'b1;
      ack_delay = 3;
      bad_tag_idx = 0;
      start_load(8);
      stream(8, 8'h20);
      wait_done(2);
      checks++;
      if (error_o !== 1'b1) begin
         errors++;
         $display("FAIL tag_error got %b expected 1", error_o);
      end
      do_reset();
      checks++;
      if (error_o !== 1'b0) begin
         errors++;
         $display("FAIL error_clear got %b expected 0", error_o);
      end
      mm_en = 1'b1;
      ack_delay = 3;
      err_idx = 1;
      start_load(8);
      stream(8, 8'h30);
      wait_done(2);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (error_o !== 1'b1 || done_o !== 1'b1) begin
         errors++;
         $display("FAIL resp_error got err=%b done=%b expected 1 1", error_o, done_o);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      mm_en = 1'b1;
      start_load(16);
      stream(6, 8'h50);
      checks++;
      if (busy_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy got %b expected 1", busy_o);
      end
      mm_en = 1'b0;
      mem_d_accept_i = 1'b0; mem_d_ack_i = 1'b0;
      rst_i = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (mem_d_wr_o !== 4'b0 || core_rst_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got wr=%h core_rst=%b busy=%b done=%b expected 0 1 0 0",
                  mem_d_wr_o, core_rst_o, busy_o, done_o);
      end
      do_reset();
      mem_d_ack_i = 1'b1; mem_d_resp_tag_i = 11'd5; mem_d_error_i = 1'b1;
      @(posedge clk); #1;
      mem_d_ack_i = 1'b0; mem_d_resp_tag_i = 11'd0; mem_d_error_i = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (error_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_ack got err=%b expected 0", error_o);
      end
      start_load(0);
      checks++;
      if (done_o !== 1'b1 || core_rst_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL zero_len got done=%b core_rst=%b busy=%b expected 1 0 0", done_o, core_rst_o, busy_o);
      end
      start_load(8);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || byte_ready_o !== 1'b0 || wr_seen != 0) begin
         errors++;
         $display("FAIL done_terminal got done=%b busy=%b rdy=%b writes=%0d expected 1 0 0 0",
                  done_o, busy_o, byte_ready_o, wr_seen);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_partial();
      test_backpressure();
      test_outstanding();
      test_errors();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no completion expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
